// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: per-stage destination scoreboard, operand
// forward selects, load-use stall with bubble, memory freeze, branch flush.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 3,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 16,
  localparam int SELW      = $clog2(NUM_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_regwrite,
  input  logic                      id_memtoreg,
  input  logic                      id_setflag,
  input  logic                      id_flag_use,
  input  logic                      br_taken,
  input  logic                      mem_busy,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      flag_fwd,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      flush_id,
  output logic                      freeze,
  output logic [NUM_STAGES-1:0]     stage_valid,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  logic              sbValid    [1:NUM_STAGES];
  logic [REG_AW-1:0] sbDst      [1:NUM_STAGES];
  logic              sbRegwrite [1:NUM_STAGES];
  logic              sbMemtoreg [1:NUM_STAGES];
  logic              sbSetflag  [1:NUM_STAGES];

  logic              luse;
  logic              hit;
  logic              found;
  logic [REG_AW-1:0] srcAddr;
  logic              take;

  // Scan stages youngest-first; a load in stage 1 is never a forward source,
  // it raises load-use instead and the scan continues to older writers.
  always_comb begin
    fwd_sel = '0;
    luse    = 1'b0;
    hit     = 1'b0;
    found   = 1'b0;
    srcAddr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      srcAddr = id_src_addr[i*REG_AW +: REG_AW];
      found   = 1'b0;
      for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
        hit = sbValid[k] && sbRegwrite[k] && (sbDst[k] == srcAddr) &&
              id_src_used[i] && (srcAddr != REG_AW'(ZERO_REG));
        if (hit && (k == 1) && sbMemtoreg[1]) begin
          luse = luse | id_valid;
        end else if (hit && !found) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stage_valid = '0;
    for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
      stage_valid[k-1] = sbValid[k];
    end
  end

  assign freeze    = mem_busy;
  assign stall_if  = mem_busy | luse;
  assign stall_id  = mem_busy | luse;
  assign bubble_ex = luse & ~mem_busy;
  assign flush_id  = id_valid & br_taken & ~luse & ~mem_busy;
  assign flag_fwd  = id_flag_use & sbValid[1] & sbSetflag[1];
  assign take      = id_valid & ~bubble_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
        sbValid[k]    <= 1'b0;
        sbDst[k]      <= '0;
        sbRegwrite[k] <= 1'b0;
        sbMemtoreg[k] <= 1'b0;
        sbSetflag[k]  <= 1'b0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      for (int unsigned k = NUM_STAGES; k > 1; k--) begin
        sbValid[k]    <= sbValid[k-1];
        sbDst[k]      <= sbDst[k-1];
        sbRegwrite[k] <= sbRegwrite[k-1];
        sbMemtoreg[k] <= sbMemtoreg[k-1];
        sbSetflag[k]  <= sbSetflag[k-1];
      end
      sbValid[1]    <= take;
      sbDst[1]      <= take ? id_dst_addr : '0;
      sbRegwrite[1] <= take & id_regwrite;
      sbMemtoreg[1] <= take & id_memtoreg;
      sbSetflag[1]  <= take & id_setflag;
      if (bubble_ex && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against an instruction-queue
// reference model (3 stages, 3 sources, 2-bit counters).
module tb_pipe_hazard_ctrl;

  localparam int NS = 3;
  localparam int NSRC = 3;
  localparam int AW = 5;
  localparam int CW = 2;
  localparam int SW = 2;
  localparam int CMAX = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [NSRC*AW-1:0] id_src_addr;
  logic [NSRC-1:0]  id_src_used;
  logic [AW-1:0]    id_dst_addr;
  logic             id_regwrite, id_memtoreg, id_setflag, id_flag_use;
  logic             br_taken, mem_busy;
  logic [NSRC*SW-1:0] fwd_sel;
  logic             flag_fwd, stall_if, stall_id, bubble_ex, flush_id, freeze;
  logic [NS-1:0]    stage_valid;
  logic [CW-1:0]    stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .NUM_SRC(NSRC), .REG_AW(AW), .ZERO_REG(31), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_setflag(id_setflag), .id_flag_use(id_flag_use),
    .br_taken(br_taken), .mem_busy(mem_busy), .fwd_sel(fwd_sel), .flag_fwd(flag_fwd),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .freeze(freeze), .stage_valid(stage_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic       sf;
  } ent_t;

  // pipe[0] is the youngest in-flight instruction (stage 1)
  ent_t pipe[$];
  int   mStall, mFlush;
  int   checks = 0;
  int   errors = 0;

  logic [NSRC*SW-1:0] eFwd;
  logic eLuse, eFlag, eStall, eBub, eFlush, eFreeze;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pipe.delete();
    repeat (NS) pipe.push_back('0);
    mStall = 0;
    mFlush = 0;
  endtask

  task automatic modelEval();
    int hits[$];
    logic [4:0] s;
    eFwd  = '0;
    eLuse = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      s = id_src_addr[i*AW +: AW];
      hits.delete();
      for (int k = 0; k < NS; k++)
        if (pipe[k].v && pipe[k].rw && pipe[k].dst == s && id_src_used[i] && s != 5'd31)
          hits.push_back(k + 1);
      if (hits.size() > 0 && hits[0] == 1 && pipe[0].mr) begin
        if (id_valid) eLuse = 1'b1;
        void'(hits.pop_front());
      end
      if (hits.size() > 0) eFwd[i*SW +: SW] = 2'(hits[0]);
    end
    eFreeze = mem_busy;
    eStall  = mem_busy | eLuse;
    eBub    = eLuse & ~mem_busy;
    eFlush  = id_valid & br_taken & ~eLuse & ~mem_busy;
    eFlag   = id_flag_use & pipe[0].v & pipe[0].sf;
  endtask

  task automatic modelUpdate();
    ent_t e;
    if (reset) begin
      modelReset();
    end else if (!mem_busy) begin
      e = '0;
      if (id_valid && !eBub) e = '{1'b1, id_dst_addr, id_regwrite, id_memtoreg, id_setflag};
      void'(pipe.pop_back());
      pipe.push_front(e);
      if (eBub && mStall < CMAX) mStall++;
      if (eFlush && mFlush < CMAX) mFlush++;
    end
  endtask

  // Inputs are already driven (just after negedge); check, then clock once.
  task automatic cyc();
    #1;
    modelEval();
    chk("fwd_sel", 32'(fwd_sel), 32'(eFwd));
    chk("flag_fwd", 32'(flag_fwd), 32'(eFlag));
    chk("stall_if", 32'(stall_if), 32'(eStall));
    chk("stall_id", 32'(stall_id), 32'(eStall));
    chk("bubble_ex", 32'(bubble_ex), 32'(eBub));
    chk("flush_id", 32'(flush_id), 32'(eFlush));
    chk("freeze", 32'(freeze), 32'(eFreeze));
    chk("stage_valid", 32'(stage_valid), 32'({pipe[2].v, pipe[1].v, pipe[0].v}));
    chk("stall_cnt", 32'(stall_cnt), 32'(mStall));
    chk("flush_cnt", 32'(flush_cnt), 32'(mFlush));
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [2:0] used, input logic [4:0] dst,
                     input logic rw, input logic mr, input logic sf, input logic fu,
                     input logic br, input logic busy);
    id_valid    = v;
    id_src_addr = {s2, s1, s0};
    id_src_used = used;
    id_dst_addr = dst;
    id_regwrite = rw;
    id_memtoreg = mr;
    id_setflag  = sf;
    id_flag_use = fu;
    br_taken    = br;
    mem_busy    = busy;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 4))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd7;
      3: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    modelReset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_fwd_sel", 32'(fwd_sel), 0);
    chk("rst_stage_valid", 32'(stage_valid), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    cyc();

    // Back-to-back ALU hazard: ADD X1, then readers of X1 at distance 1..3
    drv(1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0);
    cyc();
    drv(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0, 0, 0);
    #1;
    chk("alu_fwd1", 32'(fwd_sel[1:0]), 1);
    chk("alu_nostall", 32'(stall_if), 0);
    cyc();
    drv(1, 1, 0, 0, 3'b001, 9, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alu_fwd2", 32'(fwd_sel[1:0]), 2);
    cyc();
    drv(1, 1, 0, 0, 3'b001, 9, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alu_fwd3", 32'(fwd_sel[1:0]), 3);
    cyc();

    // Load-use: LDUR X5 then reader of X5
    drv(1, 0, 0, 0, 3'b000, 5, 1, 1, 0, 0, 0, 0);
    cyc();
    drv(1, 5, 0, 0, 3'b001, 11, 1, 0, 0, 0, 0, 0);
    #1;
    chk("lu_stall", 32'({stall_if, stall_id, bubble_ex}), 32'h7);
    chk("lu_cnt0", 32'(stall_cnt), 0);
    cyc();
    #1;
    chk("lu_retry_nostall", 32'(stall_if), 0);
    chk("lu_retry_fwd2", 32'(fwd_sel[1:0]), 2);
    chk("lu_bubble_s1", 32'(stage_valid[0]), 0);
    chk("lu_cnt1", 32'(stall_cnt), 1);
    cyc();

    // XZR never forwarded; youngest writer wins
    drv(1, 0, 0, 0, 3'b000, 31, 1, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    drv(1, 31, 31, 31, 3'b111, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("xzr_fwd", 32'(fwd_sel), 0);
    cyc();
    drv(1, 0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    drv(1, 0, 7, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("young_fwd", 32'(fwd_sel[3:2]), 1);
    cyc();

    // Flag forwarding from stage 1
    drv(1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    drv(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("flag_fwd", 32'(flag_fwd), 1);
    cyc();

    // Branch: plain flush, then branch coincident with load-use
    drv(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("br_flush", 32'(flush_id), 1);
    cyc();
    drv(1, 0, 0, 0, 3'b000, 6, 1, 1, 0, 0, 0, 0);
    #1;
    chk("br_cnt1", 32'(flush_cnt), 1);
    cyc();
    drv(1, 6, 0, 0, 3'b001, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("br_lu_noflush", 32'(flush_id), 0);
    chk("br_lu_stall", 32'(stall_if), 1);
    cyc();
    #1;
    chk("br_retry_flush", 32'(flush_id), 1);
    chk("br_retry_cnt", 32'(flush_cnt), 1);
    cyc();

    // Memory freeze with a load in stage 1
    drv(1, 0, 0, 0, 3'b000, 8, 1, 1, 0, 0, 0, 0);
    cyc();
    drv(1, 8, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("frz_freeze", 32'(freeze), 1);
      chk("frz_bubble", 32'(bubble_ex), 0);
      chk("frz_sv", 32'(stage_valid), 32'h3);
      chk("frz_cnt", 32'(stall_cnt), 2);
      cyc();
    end
    mem_busy = 1'b0;
    #1;
    chk("frz_release_bubble", 32'(bubble_ex), 1);
    cyc();
    #1;
    chk("frz_release_once", 32'(bubble_ex), 0);
    cyc();

    // Saturation from a clean start: five load-use stalls
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      drv(1, 0, 0, 0, 3'b000, 10, 1, 1, 0, 0, 0, 0);
      cyc();
      drv(1, 10, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      cyc();
    end
    idle();
    #1;
    chk("sat_stall_cnt", 32'(stall_cnt), 3);
    cyc();

    // Reset during an active stall
    drv(1, 0, 0, 0, 3'b000, 12, 1, 1, 0, 0, 0, 0);
    cyc();
    drv(1, 12, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(stall_if), 1);
    cyc();
    reset = 1'b0;
    idle();
    #1;
    chk("rst2_outs", 32'({fwd_sel, flag_fwd, stall_if, stall_id, bubble_ex, flush_id, freeze}), 0);
    chk("rst2_stage_valid", 32'(stage_valid), 0);
    chk("rst2_cnts", 32'({stall_cnt, flush_cnt}), 0);
    cyc();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      drv($urandom_range(0, 7) != 0, pickReg(), pickReg(), pickReg(),
          3'($urandom_range(0, 7)), pickReg(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
